lms_update_seq: RTL
===================

Name: lms_update_seq

Overview:
Sequential LMS weight-update engine. It owns the TAPS-entry coefficient register file and computes w[i] += 2*mu*e*x[i] using one shared multiplier pair, updating one tap per cycle.
It sits between the sample/error path (tap-delay line plus error subtractor) and the FIR that consumes the weights. It replaces a fully parallel per-tap update with a time-multiplexed, saturating one.

Parameters:
WIDTH, 16, total bits of din/error/step_size (signed Q format)
FRAC, 14, fractional bits of din/error/step_size
COEFF_WIDTH, 16, total bits of each weight (signed)
COEFF_FRAC, 14, fractional bits of each weight
TAPS, 4, number of taps/weights (>=1)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
in_valid  in  1  update request; din/error/step_size valid
in_ready  out  1  high only in IDLE; accept = in_valid & in_ready
din  in  TAPS*WIDTH  packed [TAPS-1:0][WIDTH-1:0] tap samples, sampled on accept
error  in  WIDTH  signed error e, sampled on accept
step_size  in  WIDTH  signed mu, sampled on accept
clear_weights  in  1  synchronous zero of all weights plus abort
weights  out  TAPS*COEFF_WIDTH  packed [TAPS-1:0][COEFF_WIDTH-1:0] current weight registers
busy  out  1  high in MUE/UPD/DONE
done  out  1  one-cycle pulse; all TAPS weights updated and visible
sat_flag  out  1  sticky; set on any saturation event
sat_clear  in  1  clears sat_flag

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; weights, done, busy, sat_flag=0; in_ready=0 while rst is high, 1 from the first cycle after. Reset mid-operation aborts without a done pulse.
- FSM: IDLE -> MUE on accept. MUE -> UPD (1 cycle). UPD stays TAPS cycles, tap index k=0..TAPS-1. UPD -> DONE after k=TAPS-1. DONE -> IDLE (1 cycle, done=1).
- Timing: accept at cycle T. In T+1, mu_e is registered. In cycle T+2+k, weights[k] is written and visible from T+3+k. done is high in T+2+TAPS. in_ready returns at T+3+TAPS. Request period is TAPS+3.
- Captured operands are held in registers. Input changes after accept have no effect.
- Arithmetic (all signed, truncation = arithmetic shift right, i.e. toward -inf):
  - mu_e = sat_WIDTH((step_size*error) >>> FRAC).
  - p = mu_e*din[k], a full 2*WIDTH-bit product with 2*FRAC fractional bits.
  - offset = sat_COEFF_WIDTH(p >>> SH), where SH = 2*FRAC-COEFF_FRAC-1. This folds in the x2 and the alignment.
  - weights[k] <= sat_COEFF_WIDTH(weights[k] + offset), computed at COEFF_WIDTH+1 bits.
  - SH < 0 is an elaboration-time error.
- Saturation clamps to [-2^(N-1), 2^(N-1)-1]. Any of the three clamps firing sets sat_flag on the next edge.
- sat_clear and a new saturation event in the same cycle: set wins.
- clear_weights (any state): on the next edge, weights=0, state=IDLE, no done. It has priority over an accept in the same cycle; that request is not accepted.
- Untouched taps keep their value. Weights change only in their own UPD cycle.

Decomposition:
- Package lms_pkg:
  - state enum {IDLE, MUE, UPD, DONE}
  - function sat(value, width)
  - function for the SH localparam
- One sub-module, lms_tap_mac: purely combinational, (mu_e, din_k, w_k) -> (w_next, sat). The sequencer instantiates it once.
- The sequencer holds the FSM, tap counter, operand registers and weight file.

Test Plan (WIDTH=16, FRAC=14, COEFF_WIDTH=16, COEFF_FRAC=14, TAPS=4, SH=13):
- Basic: weights 0; accept error=0x2000, step=0x2000, all din=0x1000 at T -> mu_e=0x1000; weights[k]=0x0800 visible at T+3+k; done only at T+6; sat_flag=0.
- Negative: repeat with error=0xE000 -> all weights return to 0x0000; done at T+6.
- Saturation: error=step=din=0x7FFF -> mu_e and offset clamp; weights=0x7FFF, sat_flag=1. A second identical request keeps 0x7FFF. sat_clear -> sat_flag=0.
- Back-to-back: in_valid held high with changing operands -> accepts at T, T+7, T+14. in_ready low in between. Each request uses its own captured operands.
- Abort: clear_weights at T+3 (in UPD) -> weights all 0 at T+4, state IDLE, no done pulse, in_ready=1 at T+4.
- Reset mid-op: rst at T+2 -> all outputs 0 next cycle, in_ready=1 the cycle after rst drops, no done.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared types and arithmetic helpers for the sequential LMS weight-update engine.
package lms_pkg;

    typedef enum logic [1:0] {IDLE, MUE, UPD, DONE} lms_state_t;

    // Right shift that turns mu_e*x (2*FRAC fractional bits) into a weight
    // offset (COEFF_FRAC bits), including the factor of two in 2*mu*e*x.
    function automatic int calc_sh(input int frac, input int coeff_frac);
        return 2 * frac - coeff_frac - 1;
    endfunction

    function automatic longint sat_max(input int n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

    // Clamp a signed value into the n-bit two's-complement range. Values must fit in 64 bits.
    function automatic longint sat(input longint v, input int n);
        if (v > sat_max(n))
            return sat_max(n);
        else if (v < sat_min(n))
            return sat_min(n);
        else
            return v;
    endfunction

    function automatic logic sat_hit(input longint v, input int n);
        return (v > sat_max(n)) || (v < sat_min(n));
    endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Combinational per-tap update: w_next = sat(w + sat((mu_e*x) >>> SH)), with a clamp indicator.
module lms_tap_mac
    import lms_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int SH          = 13
) (
    input  logic signed [WIDTH-1:0]       i_mu_e,
    input  logic signed [WIDTH-1:0]       i_din,
    input  logic signed [COEFF_WIDTH-1:0] i_w,
    output logic signed [COEFF_WIDTH-1:0] o_w_next,
    output logic                          o_sat
);

    logic signed [2*WIDTH-1:0]     w_p;
    logic signed [2*WIDTH-1:0]     w_p_sh;
    logic signed [COEFF_WIDTH-1:0] w_off;
    logic signed [COEFF_WIDTH:0]   w_sum;

    always_comb begin
        w_p      = (2*WIDTH)'(i_mu_e) * (2*WIDTH)'(i_din);
        w_p_sh   = w_p >>> SH;
        w_off    = COEFF_WIDTH'(sat(longint'(w_p_sh), COEFF_WIDTH));
        // One guard bit is enough for the sum of two in-range weights.
        w_sum    = (COEFF_WIDTH+1)'(i_w) + (COEFF_WIDTH+1)'(w_off);
        o_w_next = COEFF_WIDTH'(sat(longint'(w_sum), COEFF_WIDTH));
        o_sat    = sat_hit(longint'(w_p_sh), COEFF_WIDTH) | sat_hit(longint'(w_sum), COEFF_WIDTH);
    end

endmodule

// File: rtl/lms_update_seq.sv
// Time-multiplexed LMS weight update: one shared MAC, one tap per cycle, saturating weights.
module lms_update_seq
    import lms_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FRAC        = 14,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 14,
    parameter int TAPS        = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [TAPS-1:0][WIDTH-1:0]          din,
    input  logic signed [WIDTH-1:0]             error,
    input  logic signed [WIDTH-1:0]             step_size,
    input  logic                                clear_weights,
    output logic [TAPS-1:0][COEFF_WIDTH-1:0]    weights,
    output logic                                busy,
    output logic                                done,
    output logic                                sat_flag,
    input  logic                                sat_clear
);

    localparam int SH = calc_sh(FRAC, COEFF_FRAC);
    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

    if (SH < 0) begin : g_sh_check
        $error("lms_update_seq: 2*FRAC-COEFF_FRAC-1 must be non-negative");
    end

    lms_state_t                      r_state;
    logic [KW-1:0]                   r_k;
    logic signed [WIDTH-1:0]         r_step_p0;
    logic signed [WIDTH-1:0]         r_err_p0;
    logic [TAPS-1:0][WIDTH-1:0]      r_din_p0;
    logic signed [WIDTH-1:0]         r_mu_e_p1;
    logic [TAPS-1:0][COEFF_WIDTH-1:0] r_w;
    logic                            r_sat;

    logic                            w_accept;
    logic signed [2*WIDTH-1:0]       w_prod;
    logic signed [2*WIDTH-1:0]       w_prod_sh;
    logic signed [WIDTH-1:0]         w_mu_e;
    logic                            w_mu_sat;
    logic signed [COEFF_WIDTH-1:0]   w_w_next;
    logic                            w_mac_sat;
    logic                            w_sat_evt;

    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready && !clear_weights;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign weights  = r_w;
    assign sat_flag = r_sat;

    // Stage 0 -> 1: mu_e from the captured step and error
    always_comb begin
        w_prod    = (2*WIDTH)'(r_step_p0) * (2*WIDTH)'(r_err_p0);
        w_prod_sh = w_prod >>> FRAC;
        w_mu_e    = WIDTH'(sat(longint'(w_prod_sh), WIDTH));
        w_mu_sat  = sat_hit(longint'(w_prod_sh), WIDTH);
    end

    // Stage 1 -> weight file: shared MAC on tap r_k
    lms_tap_mac #(
        .WIDTH       (WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .SH          (SH)
    ) u_mac (
        .i_mu_e   (r_mu_e_p1),
        .i_din    (r_din_p0[r_k]),
        .i_w      (r_w[r_k]),
        .o_w_next (w_w_next),
        .o_sat    (w_mac_sat)
    );

    assign w_sat_evt = ((r_state == MUE) && w_mu_sat) || ((r_state == UPD) && w_mac_sat);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_step_p0 <= step_size;
            r_err_p0  <= error;
            r_din_p0  <= din;
        end
        if (r_state == MUE)
            r_mu_e_p1 <= w_mu_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_w     <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_sat_evt)
                r_sat <= 1'b1;
            else if (sat_clear)
                r_sat <= 1'b0;

            if (clear_weights) begin
                r_state <= IDLE;
                r_k     <= '0;
                r_w     <= '0;
            end else begin
                case (r_state)
                    IDLE: if (w_accept) r_state <= MUE;
                    MUE:  r_state <= UPD;
                    UPD: begin
                        r_w[r_k] <= w_w_next;
                        if (r_k == KW'(TAPS - 1)) begin
                            r_k     <= '0;
                            r_state <= DONE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                    DONE: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
